// File: rtl/smu_dcu_arb.sv
// Arbitrates istore-miss, dribbler spill and dribbler fill traffic onto
// the single DCU command port, with load-return tracking and flush kill.
module smu_dcu_arb #(
   parameter int RF_AW = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             smiss_req,
   input  logic [31:0]      smiss_addr,
   input  logic [31:0]      smiss_data,
   input  logic             spill_req,
   input  logic [31:0]      spill_addr,
   input  logic [31:0]      spill_data,
   input  logic             fill_req,
   input  logic [31:0]      fill_addr,
   input  logic [RF_AW-1:0] fill_rf_addr,
   output logic             smiss_gnt,
   output logic             spill_gnt,
   output logic             fill_gnt,
   input  logic             dcu_smu_stall,
   input  logic             smu_data_vld,
   input  logic             iu_smu_flush,
   output logic             smu_ld,
   output logic             smu_st,
   output logic             smu_na_st,
   output logic [31:0]      smu_addr,
   output logic [31:0]      smu_data,
   output logic             smu_we,
   output logic [RF_AW-1:0] smu_rf_addr,
   output logic             arb_busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, LDWAIT} state_t;
   typedef enum logic [1:0] {OWN_SMISS, OWN_SPILL, OWN_FILL} own_t;

   state_t           state_q, state_d;
   own_t             own_q, own_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      data_q, data_d;
   logic [RF_AW-1:0] rf_q, rf_d;
   logic             last_fill_q, last_fill_d;
   logic             kill_q, kill_d;
   logic             fill_ok, spill_ok, accept, issue;

   assign fill_ok  = fill_req & ~iu_smu_flush;
   assign spill_ok = spill_req & ~iu_smu_flush;
   assign accept   = (state_q == ISSUE) & ~dcu_smu_stall;

   always_comb begin
      state_d     = state_q;
      own_d       = own_q;
      addr_d      = addr_q;
      data_d      = data_q;
      rf_d        = rf_q;
      last_fill_d = last_fill_q;
      kill_d      = kill_q;
      unique case (state_q)
         IDLE: begin
            if (smiss_req) begin
               own_d   = OWN_SMISS;
               addr_d  = smiss_addr;
               data_d  = smiss_data;
               state_d = ISSUE;
            end else if (fill_ok && (!spill_ok || !last_fill_q)) begin
               own_d   = OWN_FILL;
               addr_d  = fill_addr;
               data_d  = '0;
               rf_d    = fill_rf_addr;
               state_d = ISSUE;
            end else if (spill_ok) begin
               own_d   = OWN_SPILL;
               addr_d  = spill_addr;
               data_d  = spill_data;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (accept) begin
               if (own_q == OWN_FILL) begin
                  state_d     = LDWAIT;
                  last_fill_d = 1'b1;
                  kill_d      = iu_smu_flush;
               end else begin
                  state_d = IDLE;
                  if (own_q == OWN_SPILL) last_fill_d = 1'b0;
               end
            end else if (iu_smu_flush && own_q != OWN_SMISS) begin
               // stalled dribbler command is simply dropped
               state_d = IDLE;
            end
         end
         LDWAIT: begin
            if (smu_data_vld) begin
               state_d = IDLE;
               kill_d  = 1'b0;
            end else if (iu_smu_flush) begin
               kill_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         own_q       <= OWN_SMISS;
         addr_q      <= '0;
         data_q      <= '0;
         rf_q        <= '0;
         last_fill_q <= 1'b0;
         kill_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         own_q       <= own_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         rf_q        <= rf_d;
         last_fill_q <= last_fill_d;
         kill_q      <= kill_d;
      end
   end

   assign issue       = ~reset & (state_q == ISSUE);
   assign smu_ld      = issue & (own_q == OWN_FILL);
   assign smu_st      = issue & (own_q != OWN_FILL);
   assign smu_na_st   = issue & (own_q == OWN_SMISS);
   assign smu_addr    = issue ? addr_q : '0;
   assign smu_data    = smu_st ? data_q : '0;
   assign smiss_gnt   = issue & ~dcu_smu_stall & (own_q == OWN_SMISS);
   assign spill_gnt   = issue & ~dcu_smu_stall & (own_q == OWN_SPILL);
   assign fill_gnt    = issue & ~dcu_smu_stall & (own_q == OWN_FILL);
   assign smu_we      = ~reset & (state_q == LDWAIT) & smu_data_vld & ~kill_q;
   assign smu_rf_addr = smu_we ? rf_q : '0;
   assign arb_busy    = ~reset & (state_q != IDLE);

endmodule

// File: tb/tb_smu_dcu_arb.sv
// Directed bench for smu_dcu_arb: issue timing, stall, priority,
// fairness, flush and reset-during-load behaviour.
module tb_smu_dcu_arb;

   localparam int RF_AW = 6;

   logic             clk = 1'b0;
   logic             reset;
   logic             smiss_req, spill_req, fill_req;
   logic [31:0]      smiss_addr, smiss_data;
   logic [31:0]      spill_addr, spill_data, fill_addr;
   logic [RF_AW-1:0] fill_rf_addr;
   logic             smiss_gnt, spill_gnt, fill_gnt;
   logic             dcu_smu_stall, smu_data_vld, iu_smu_flush;
   logic             smu_ld, smu_st, smu_na_st, smu_we, arb_busy;
   logic [31:0]      smu_addr, smu_data;
   logic [RF_AW-1:0] smu_rf_addr;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   smu_dcu_arb #(.RF_AW(RF_AW)) dut (
      .clk(clk), .reset(reset),
      .smiss_req(smiss_req), .smiss_addr(smiss_addr),
      .smiss_data(smiss_data),
      .spill_req(spill_req), .spill_addr(spill_addr),
      .spill_data(spill_data),
      .fill_req(fill_req), .fill_addr(fill_addr),
      .fill_rf_addr(fill_rf_addr),
      .smiss_gnt(smiss_gnt), .spill_gnt(spill_gnt),
      .fill_gnt(fill_gnt),
      .dcu_smu_stall(dcu_smu_stall), .smu_data_vld(smu_data_vld),
      .iu_smu_flush(iu_smu_flush),
      .smu_ld(smu_ld), .smu_st(smu_st), .smu_na_st(smu_na_st),
      .smu_addr(smu_addr), .smu_data(smu_data),
      .smu_we(smu_we), .smu_rf_addr(smu_rf_addr),
      .arb_busy(arb_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   int seq[5];
   int exp_seq[5] = '{0, 1, 2, 1, 2};
   int ng;

   initial begin
      reset = 1'b1;
      smiss_req = 0; smiss_addr = 0; smiss_data = 0;
      spill_req = 0; spill_addr = 0; spill_data = 0;
      fill_req = 0; fill_addr = 0; fill_rf_addr = 0;
      dcu_smu_stall = 0; smu_data_vld = 0; iu_smu_flush = 0;

      // reset state
      @(negedge clk); @(negedge clk); #1;
      chk("rst_busy", arb_busy, 0);
      chk("rst_st", smu_st, 0);
      chk("rst_ld", smu_ld, 0);
      chk("rst_addr", smu_addr, 0);
      chk("rst_we", smu_we, 0);
      reset = 1'b0;

      // spill store, no stall
      @(negedge clk);
      spill_req = 1; spill_addr = 32'h100; spill_data = 32'hCAFE;
      #1;
      chk("sp0_st", smu_st, 0);
      chk("sp0_busy", arb_busy, 0);
      @(negedge clk); #1;
      chk("sp1_st", smu_st, 1);
      chk("sp1_addr", smu_addr, 32'h100);
      chk("sp1_data", smu_data, 32'hCAFE);
      chk("sp1_gnt", spill_gnt, 1);
      chk("sp1_na", smu_na_st, 0);
      chk("sp1_busy", arb_busy, 1);
      spill_req = 0;
      @(negedge clk); #1;
      chk("sp2_st", smu_st, 0);
      chk("sp2_gnt", spill_gnt, 0);
      chk("sp2_busy", arb_busy, 0);

      // priority and fill/spill alternation
      @(negedge clk);
      smiss_req = 1; smiss_addr = 32'h300; smiss_data = 32'h11;
      fill_req = 1; fill_addr = 32'h400; fill_rf_addr = 7;
      spill_req = 1; spill_addr = 32'h500; spill_data = 32'h22;
      smu_data_vld = 1;
      ng = 0;
      for (int c = 0; c < 20 && ng < 5; c++) begin
         @(negedge clk); #1;
         if (smiss_gnt) begin
            chk("pri_na", smu_na_st, 1);
            seq[ng] = 0; ng++;
            smiss_req = 0;
         end else if (fill_gnt) begin
            chk("pri_ld", smu_ld, 1);
            seq[ng] = 1; ng++;
         end else if (spill_gnt) begin
            chk("pri_spna", smu_na_st, 0);
            seq[ng] = 2; ng++;
         end
      end
      chk("pri_cnt", ng, 5);
      for (int i = 0; i < 5; i++)
         if (i < ng) chk($sformatf("pri_seq%0d", i), seq[i], exp_seq[i]);
      fill_req = 0; spill_req = 0; smu_data_vld = 0;
      @(negedge clk); #1;
      chk("pri_idle", arb_busy, 0);

      // stalled fill, then data return
      fill_req = 1; fill_addr = 32'h200; fill_rf_addr = 5;
      dcu_smu_stall = 1;
      @(negedge clk); #1;
      chk("fl1_ld", smu_ld, 1);
      chk("fl1_gnt", fill_gnt, 0);
      chk("fl1_addr", smu_addr, 32'h200);
      chk("fl1_data", smu_data, 0);
      @(negedge clk);
      smu_data_vld = 1;
      #1;
      chk("fl2_ld", smu_ld, 1);
      chk("fl2_gnt", fill_gnt, 0);
      chk("fl2_we", smu_we, 0);
      @(negedge clk);
      smu_data_vld = 0;
      #1;
      chk("fl3_ld", smu_ld, 1);
      chk("fl3_gnt", fill_gnt, 0);
      @(negedge clk);
      dcu_smu_stall = 0;
      #1;
      chk("fl4_ld", smu_ld, 1);
      chk("fl4_gnt", fill_gnt, 1);
      fill_req = 0;
      @(negedge clk); #1;
      chk("fl5_ld", smu_ld, 0);
      chk("fl5_busy", arb_busy, 1);
      chk("fl5_we", smu_we, 0);
      @(negedge clk);
      smu_data_vld = 1;
      #1;
      chk("fl6_we", smu_we, 1);
      chk("fl6_rf", smu_rf_addr, 5);
      @(negedge clk);
      smu_data_vld = 0;
      #1;
      chk("fl7_we", smu_we, 0);
      chk("fl7_busy", arb_busy, 0);

      // flush during a stalled spill, then flush masking in IDLE
      spill_req = 1; spill_addr = 32'h600; spill_data = 32'h33;
      dcu_smu_stall = 1;
      @(negedge clk);
      iu_smu_flush = 1;
      #1;
      chk("fs1_st", smu_st, 1);
      chk("fs1_gnt", spill_gnt, 0);
      @(negedge clk); #1;
      chk("fs2_st", smu_st, 0);
      chk("fs2_busy", arb_busy, 0);
      @(negedge clk); #1;
      chk("fs3_mask", arb_busy, 0);
      spill_req = 0; iu_smu_flush = 0; dcu_smu_stall = 0;

      // flush ignored for an smiss owner
      smiss_req = 1; smiss_addr = 32'h800; smiss_data = 32'h44;
      dcu_smu_stall = 1;
      @(negedge clk);
      iu_smu_flush = 1;
      #1;
      chk("sm1_na", smu_na_st, 1);
      chk("sm1_gnt", smiss_gnt, 0);
      @(negedge clk);
      iu_smu_flush = 0; dcu_smu_stall = 0;
      #1;
      chk("sm2_st", smu_st, 1);
      chk("sm2_data", smu_data, 32'h44);
      chk("sm2_gnt", smiss_gnt, 1);
      smiss_req = 0;
      @(negedge clk); #1;
      chk("sm3_busy", arb_busy, 0);

      // flush during LDWAIT kills the write
      fill_req = 1; fill_addr = 32'h700; fill_rf_addr = 9;
      @(negedge clk); #1;
      chk("fk1_gnt", fill_gnt, 1);
      fill_req = 0;
      @(negedge clk);
      iu_smu_flush = 1;
      #1;
      chk("fk2_busy", arb_busy, 1);
      @(negedge clk);
      iu_smu_flush = 0; smu_data_vld = 1;
      #1;
      chk("fk3_we", smu_we, 0);
      @(negedge clk);
      smu_data_vld = 0;
      #1;
      chk("fk4_busy", arb_busy, 0);

      // reset in LDWAIT abandons the load
      fill_req = 1; fill_addr = 32'h900; fill_rf_addr = 3;
      @(negedge clk); #1;
      chk("rl1_gnt", fill_gnt, 1);
      fill_req = 0;
      @(negedge clk);
      reset = 1;
      #1;
      chk("rl2_busy", arb_busy, 0);
      @(negedge clk);
      reset = 0; smu_data_vld = 1;
      #1;
      chk("rl3_we", smu_we, 0);
      chk("rl3_busy", arb_busy, 0);
      @(negedge clk);
      smu_data_vld = 0;
      spill_req = 1; spill_addr = 32'hA00; spill_data = 32'h55;
      @(negedge clk); #1;
      chk("rl5_st", smu_st, 1);
      chk("rl5_addr", smu_addr, 32'hA00);
      chk("rl5_gnt", spill_gnt, 1);
      spill_req = 0;
      @(negedge clk); #1;
      chk("rl6_busy", arb_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/smu_dcu_arb.md
SMU_DCU_ARB -- requirements
Module: smu_dcu_arb

Interface
REQ-001 The block SHALL have parameter RF_AW, default 6, giving the register-file address width.
REQ-002 The block SHALL run on one clock and use a synchronous, active-high reset.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- smiss_req  in  1  istore-miss store request.
- smiss_addr  in  32  store address for smiss_req.
- smiss_data  in  32  store data for smiss_req.
- spill_req  in  1  dribbler spill-store request.
- spill_addr  in  32  store address for spill_req.
- spill_data  in  32  store data for spill_req.
- fill_req  in  1  dribbler fill-load request.
- fill_addr  in  32  load address for fill_req.
- fill_rf_addr  in  RF_AW  register-file destination for the fill.
- smiss_gnt  out  1  acceptance pulse for the smiss request.
- spill_gnt  out  1  acceptance pulse for the spill request.
- fill_gnt  out  1  acceptance pulse for the fill request.
- dcu_smu_stall  in  1  DCU cannot accept the presented command.
- smu_data_vld  in  1  load data valid from the DCU.
- iu_smu_flush  in  1  cancel dribbler traffic.
- smu_ld  out  1  load command to the DCU.
- smu_st  out  1  store command to the DCU.
- smu_na_st  out  1  marks the store as non-allocate.
- smu_addr  out  32  command address.
- smu_data  out  32  store data.
- smu_we  out  1  register-file write enable for returned fill data.
- smu_rf_addr  out  RF_AW  register-file write address.
- arb_busy  out  1  controller state is not IDLE.

Function
REQ-004 The controller SHALL have exactly three states: IDLE, ISSUE, LDWAIT.
REQ-005 In IDLE with any request asserted, the block SHALL pick one winner, register its type, address, data and rf address, and enter ISSUE; a request sampled in cycle N drives smu_ld/smu_st in cycle N+1.
REQ-006 Request priority SHALL be smiss first; fill and spill, when both request, SHALL alternate using a last-granted flag that updates only on acceptance.
REQ-007 Requests SHALL be sampled only in IDLE; a requester holds its req and payload stable until its gnt.
REQ-008 In ISSUE, smu_ld/smu_st, smu_addr, smu_data and smu_na_st SHALL stay stable while dcu_smu_stall=1.
REQ-009 The command SHALL be accepted in the first ISSUE cycle with dcu_smu_stall=0.
REQ-010 The owner's gnt SHALL be asserted combinationally in the acceptance cycle only, for exactly one cycle.
REQ-011 After an accepted store, the block SHALL return to IDLE; after an accepted load, it SHALL enter LDWAIT.
REQ-012 smu_ld/smu_st SHALL deassert the cycle after acceptance, so back-to-back commands are separated by one IDLE cycle.
REQ-013 Only one load SHALL be outstanding, and no new arbitration SHALL occur in LDWAIT.
REQ-014 In LDWAIT, smu_data_vld SHALL produce a one-cycle smu_we in the same cycle, with smu_rf_addr equal to the latched fill_rf_addr, and the state SHALL return to IDLE.
REQ-015 smu_data_vld SHALL be ignored in IDLE and ISSUE.
REQ-016 smu_na_st SHALL be 1 only while an smiss store is presented; spill stores present smu_na_st=0.
REQ-017 smu_data SHALL be 0 for loads.
REQ-018 Flush in IDLE: iu_smu_flush=1 SHALL mask fill_req and spill_req that cycle; smiss_req remains eligible.
REQ-019 Flush in ISSUE with a dribbler owner and dcu_smu_stall=1: the command SHALL be dropped, no gnt issued, outputs 0 the next cycle, and the state SHALL return to IDLE.
REQ-020 Flush in ISSUE with an smiss owner: the flush SHALL be ignored.
REQ-021 Flush coinciding with acceptance: acceptance SHALL win and gnt is issued; for a fill, the kill flag SHALL be set.
REQ-022 Flush in LDWAIT SHALL set the kill flag; the next smu_data_vld still ends LDWAIT, but smu_we SHALL stay 0.
REQ-023 The kill flag SHALL clear on leaving LDWAIT.
REQ-024 arb_busy SHALL equal (state != IDLE).

Reset
REQ-025 While reset=1, the block SHALL force state IDLE, all outputs 0, the last-granted flag to "spill" (fill wins the first tie), and the kill flag to 0.
REQ-026 Reset asserted during LDWAIT SHALL abandon the load; a later smu_data_vld SHALL produce no smu_we.

Verification
REQ-027 The bench SHALL cover a spill store with no stall: spill_req=1, spill_addr=0x100, spill_data=0xCAFE at cycle 0 -> smu_st=1, smu_addr=0x100, smu_data=0xCAFE, spill_gnt=1 at cycle 1; smu_st=0 at cycle 2.
REQ-028 The bench SHALL cover a stalled fill: fill_req=1, fill_addr=0x200, fill_rf_addr=5, dcu_smu_stall=1 for 3 cycles -> smu_ld held for 4 cycles with fill_gnt only in the 4th; smu_data_vld 2 cycles later -> smu_we=1, smu_rf_addr=5 for one cycle.
REQ-029 The bench SHALL cover priority and fairness: smiss, fill and spill all requesting continuously -> grant order smiss, fill, spill, fill, spill while smiss stays low after its first gnt.
REQ-030 The bench SHALL cover flush: iu_smu_flush during a stalled spill -> no spill_gnt, smu_st=0 next cycle; iu_smu_flush during LDWAIT -> smu_data_vld ends LDWAIT with smu_we=0.
REQ-031 The bench SHALL cover reset mid-load: reset for 1 cycle in LDWAIT, then smu_data_vld=1 -> smu_we=0, arb_busy=0, and the next request issues normally.
